// File: rtl/mem_port_arbiter_if.sv
// Pipeline-side and memory-side handshake bundle for mem_port_arbiter.
// slave is the arbiter's view; master is the pipeline/memory environment's view.
interface mem_port_arbiter_if;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_done;
   logic [31:0] if_rdata;
   logic        if_stall;

   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_done;
   logic [31:0] mem_rdata;
   logic        mem_stall;

   logic        ram_req;
   logic        ram_we;
   logic [31:0] ram_addr;
   logic [31:0] ram_wdata;
   logic [31:0] ram_rdata;
   logic        ram_ack;
   logic        bus_err;

   modport slave (
      input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, ram_rdata, ram_ack,
      output if_done, if_rdata, if_stall, mem_done, mem_rdata, mem_stall,
             ram_req, ram_we, ram_addr, ram_wdata, bus_err
   );

   modport master (
      output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, ram_rdata, ram_ack,
      input  if_done, if_rdata, if_stall, mem_done, mem_rdata, mem_stall,
             ram_req, ram_we, ram_addr, ram_wdata, bus_err
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter for a single-ported unified memory, with wait-state timeout.
// Optional ARB_PERF_CNT_EN adds stall and forced-fetch performance counters.
module mem_port_arbiter #(
   parameter int unsigned MAX_DSTREAK = 4,
   parameter int unsigned TIMEOUT     = 64
) (
   input  logic                clk,
   input  logic                rst_n,
   mem_port_arbiter_if.slave   bus
`ifdef ARB_PERF_CNT_EN
   ,
   output logic [31:0]         perf_if_stall,
   output logic [31:0]         perf_mem_stall,
   output logic [15:0]         perf_forced
`endif
);

   localparam logic [1:0]  StIdle     = 2'd0;
   localparam logic [1:0]  StIssue    = 2'd1;
   localparam logic [1:0]  StResp     = 2'd2;
   localparam logic [3:0]  MaxDs      = 4'(MAX_DSTREAK);
   localparam logic [7:0]  TimeoutVal = 8'(TIMEOUT);
   localparam logic [31:0] Nop        = 32'h0000_0013;
   localparam logic [31:0] WordMask   = 32'hFFFF_FFFC;

   logic [1:0]  state_q;
   logic        owner_q;  // 1 = data port owns the current transaction
   logic        ram_req_q;
   logic        ram_we_q;
   logic [31:0] ram_addr_q;
   logic [31:0] ram_wdata_q;
   logic [7:0]  wait_q;
   logic [3:0]  dstreak_q;
   logic [31:0] if_rdata_q;
   logic [31:0] mem_rdata_q;
   logic        bus_err_q;

   logic at_max;
   logic grant_fetch;
   logic timeout_hit;

   assign at_max      = (dstreak_q == MaxDs);
   assign grant_fetch = bus.if_req & (~bus.mem_req | at_max);
   // An ack in the final wait cycle takes precedence over the abort.
   assign timeout_hit = ~bus.ram_ack & ((wait_q + 8'd1) == TimeoutVal);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         owner_q     <= 1'b0;
         ram_req_q   <= 1'b0;
         ram_we_q    <= 1'b0;
         ram_addr_q  <= '0;
         ram_wdata_q <= '0;
         wait_q      <= '0;
         dstreak_q   <= '0;
         if_rdata_q  <= '0;
         mem_rdata_q <= '0;
         bus_err_q   <= 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               if (bus.if_req | bus.mem_req) begin
                  state_q   <= StIssue;
                  ram_req_q <= 1'b1;
                  wait_q    <= '0;
                  if (grant_fetch) begin
                     owner_q     <= 1'b0;
                     ram_we_q    <= 1'b0;
                     ram_addr_q  <= bus.if_addr & WordMask;
                     ram_wdata_q <= '0;
                     dstreak_q   <= '0;
                  end else begin
                     owner_q     <= 1'b1;
                     ram_we_q    <= bus.mem_we;
                     ram_addr_q  <= bus.mem_addr & WordMask;
                     ram_wdata_q <= bus.mem_wdata;
                     if (!bus.if_req) begin
                        dstreak_q <= '0;
                     end else if (!at_max) begin
                        dstreak_q <= dstreak_q + 4'd1;
                     end
                  end
               end
            end
            StIssue: begin
               wait_q <= wait_q + 8'd1;
               if (bus.ram_ack) begin
                  if (!owner_q) begin
                     if_rdata_q <= bus.ram_rdata;
                  end else if (!ram_we_q) begin
                     mem_rdata_q <= bus.ram_rdata;
                  end
               end else if (timeout_hit) begin
                  bus_err_q <= 1'b1;
                  if (!owner_q) begin
                     if_rdata_q <= Nop;
                  end else if (!ram_we_q) begin
                     mem_rdata_q <= '0;
                  end
               end
               if (bus.ram_ack | timeout_hit) begin
                  state_q     <= StResp;
                  ram_req_q   <= 1'b0;
                  ram_we_q    <= 1'b0;
                  ram_addr_q  <= '0;
                  ram_wdata_q <= '0;
               end
            end
            StResp: begin
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign bus.ram_req   = ram_req_q;
   assign bus.ram_we    = ram_we_q;
   assign bus.ram_addr  = ram_addr_q;
   assign bus.ram_wdata = ram_wdata_q;
   assign bus.if_rdata  = if_rdata_q;
   assign bus.mem_rdata = mem_rdata_q;
   assign bus.bus_err   = bus_err_q;
   assign bus.if_done   = (state_q == StResp) & ~owner_q;
   assign bus.mem_done  = (state_q == StResp) & owner_q;
   assign bus.if_stall  = bus.if_req & ~bus.if_done;
   assign bus.mem_stall = bus.mem_req & ~bus.mem_done;

`ifdef ARB_PERF_CNT_EN
   logic forced;
   assign forced = (state_q == StIdle) & bus.if_req & bus.mem_req & at_max;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_if_stall  <= '0;
         perf_mem_stall <= '0;
         perf_forced    <= '0;
      end else begin
         if (bus.if_stall) begin
            perf_if_stall <= perf_if_stall + 32'd1;
         end
         if (bus.mem_stall) begin
            perf_mem_stall <= perf_mem_stall + 32'd1;
         end
         if (forced) begin
            perf_forced <= perf_forced + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus queues expected responses,
// monitors on the done pulses and on the memory side pop and compare them.
module tb_mem_port_arbiter;

   typedef struct {
      logic        is_mem;
      logic [31:0] rdata;
      logic        err;
   } done_t;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
   } ram_t;

   logic clk;
   logic rst_n;

   mem_port_arbiter_if bus ();

`ifdef ARB_PERF_CNT_EN
   logic [31:0] perf_if_stall;
   logic [31:0] perf_mem_stall;
   logic [15:0] perf_forced;
`endif

   mem_port_arbiter #(
      .MAX_DSTREAK (4),
      .TIMEOUT     (64)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
`ifdef ARB_PERF_CNT_EN
      ,
      .perf_if_stall  (perf_if_stall),
      .perf_mem_stall (perf_mem_stall),
      .perf_forced    (perf_forced)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   done_t exp_q[$];
   ram_t  ram_q[$];

   logic [31:0] mem [0:255];
   int          ack_delay = 1;  // 0 = never acknowledge
   int          icnt      = 0;
   int          last_len  = 0;
   logic        prev_done = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      chk(name, {31'd0, act}, {31'd0, exp});
   endtask

   task automatic push_done(input logic is_mem, input logic [31:0] rdata, input logic err);
      done_t d;
      d.is_mem = is_mem;
      d.rdata  = rdata;
      d.err    = err;
      exp_q.push_back(d);
   endtask

   task automatic push_ram(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
      ram_t r;
      r.we    = we;
      r.addr  = addr;
      r.wdata = wdata;
      ram_q.push_back(r);
   endtask

   // Memory model plus memory-side monitor.
   always @(negedge clk) begin
      ram_t r;
      if (bus.ram_req) begin
         icnt++;
         if (icnt == 1) begin
            chk1("ram_expected", ram_q.size() != 0, 1'b1);
            if (ram_q.size() != 0) begin
               r = ram_q.pop_front();
               chk("ram_addr", bus.ram_addr, r.addr);
               chk1("ram_we", bus.ram_we, r.we);
               chk("ram_wdata", bus.ram_wdata, r.wdata);
            end
         end
         bus.ram_rdata = mem[bus.ram_addr[9:2]];
         bus.ram_ack   = (ack_delay != 0) && (icnt == ack_delay);
         if (bus.ram_ack && bus.ram_we) mem[bus.ram_addr[9:2]] = bus.ram_wdata;
      end else begin
         if (icnt != 0) last_len = icnt;
         icnt        = 0;
         bus.ram_ack = 1'b0;
      end
   end

   // Response monitor.
   always @(negedge clk) begin
      done_t e;
      if (bus.if_done || bus.mem_done) begin
         chk1("done_pulse", prev_done, 1'b0);
         chk1("done_expected", exp_q.size() != 0, 1'b1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk1("done_owner", bus.mem_done, e.is_mem);
            if (e.is_mem) chk("mem_rdata", bus.mem_rdata, e.rdata);
            else          chk("if_rdata", bus.if_rdata, e.rdata);
            chk1("done_bus_err", bus.bus_err, e.err);
         end
      end
      prev_done = bus.if_done | bus.mem_done;
   end

   task automatic fetch_req(input logic [31:0] a);
      int seen = 0;
      @(negedge clk);
      bus.if_addr = a;
      bus.if_req  = 1'b1;
      for (int i = 0; i < 400 && seen < 1; i++) begin
         @(negedge clk);
         if (bus.if_done) seen++;
      end
      bus.if_req = 1'b0;
      chk("fetch_wait", 32'(seen), 32'd1);
   endtask

   task automatic mem_op(input logic we, input logic [31:0] a, input logic [31:0] wd,
                         input int n);
      int seen = 0;
      @(negedge clk);
      bus.mem_we    = we;
      bus.mem_addr  = a;
      bus.mem_wdata = wd;
      bus.mem_req   = 1'b1;
      for (int i = 0; i < 400 && seen < n; i++) begin
         @(negedge clk);
         if (bus.mem_done) seen++;
      end
      bus.mem_req = 1'b0;
      chk("mem_wait", 32'(seen), 32'(n));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      mem[65]  = 32'h0050_0093;  // 0x104
      mem[16]  = 32'h1111_1111;  // 0x40
      mem[128] = 32'hCAFE_0001;  // 0x200
      mem[193] = 32'h0000_ABCD;  // 0x304
      rst_n         = 1'b0;
      bus.if_req    = 1'b0;
      bus.if_addr   = '0;
      bus.mem_req   = 1'b0;
      bus.mem_we    = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      bus.ram_ack   = 1'b0;
      bus.ram_rdata = '0;

      repeat (2) @(negedge clk);
      chk1("rst_ram_req", bus.ram_req, 1'b0);
      chk1("rst_if_done", bus.if_done, 1'b0);
      chk1("rst_mem_done", bus.mem_done, 1'b0);
      chk("rst_if_rdata", bus.if_rdata, 32'h0);
      chk("rst_mem_rdata", bus.mem_rdata, 32'h0);
      chk1("rst_bus_err", bus.bus_err, 1'b0);
      rst_n = 1'b1;
      @(negedge clk);
      chk1("idle_ram_req", bus.ram_req, 1'b0);

      // Lone fetch with explicit latency checks.
      ack_delay = 1;
      push_ram(1'b0, 32'h104, 32'h0);
      push_done(1'b0, 32'h0050_0093, 1'b0);
      bus.if_addr = 32'h104;
      bus.if_req  = 1'b1;
      #1 chk1("lone_stall_n", bus.if_stall, 1'b1);
      @(negedge clk);
      chk1("lone_issue_req", bus.ram_req, 1'b1);
      chk1("lone_stall_n1", bus.if_stall, 1'b1);
      chk1("lone_done_n1", bus.if_done, 1'b0);
      @(negedge clk);
      chk1("lone_done_n2", bus.if_done, 1'b1);
      chk1("lone_stall_n2", bus.if_stall, 1'b0);
      bus.if_req = 1'b0;
      @(negedge clk);

      // Simultaneous store and fetch: data first, mem_rdata untouched by the store.
      push_ram(1'b1, 32'h2000, 32'hDEAD_BEEF);
      push_ram(1'b0, 32'h104, 32'h0);
      push_done(1'b1, 32'h0, 1'b0);
      push_done(1'b0, 32'h0050_0093, 1'b0);
      fork
         fetch_req(32'h104);
         mem_op(1'b1, 32'h2003, 32'hDEAD_BEEF, 1);
      join
      push_ram(1'b0, 32'h2000, 32'h0);
      push_done(1'b1, 32'hDEAD_BEEF, 1'b0);
      mem_op(1'b0, 32'h2000, 32'h0, 1);

      // Data streak with fetch pending, twice to show the streak restarts.
      for (int round = 0; round < 2; round++) begin
         for (int k = 0; k < 4; k++) begin
            push_ram(1'b0, 32'h40, 32'h0);
            push_done(1'b1, 32'h1111_1111, 1'b0);
         end
         push_ram(1'b0, 32'h104, 32'h0);
         push_done(1'b0, 32'h0050_0093, 1'b0);
         push_ram(1'b0, 32'h40, 32'h0);
         push_done(1'b1, 32'h1111_1111, 1'b0);
         fork
            fetch_req(32'h104);
            mem_op(1'b0, 32'h40, 32'h0, 5);
         join
      end

      // Ack on the last allowed wait cycle completes normally.
      ack_delay = 64;
      push_ram(1'b0, 32'h200, 32'h0);
      push_done(1'b0, 32'hCAFE_0001, 1'b0);
      fetch_req(32'h200);
      @(negedge clk);
      chk("ack64_len", 32'(last_len), 32'd64);
      chk1("ack64_bus_err", bus.bus_err, 1'b0);

      // No ack: fetch aborts with NOP, then load aborts with zero.
      ack_delay = 0;
      push_ram(1'b0, 32'h300, 32'h0);
      push_done(1'b0, 32'h0000_0013, 1'b1);
      fetch_req(32'h300);
      @(negedge clk);
      chk("tmo_len", 32'(last_len), 32'd64);
      chk1("tmo_ram_req_low", bus.ram_req, 1'b0);
      push_ram(1'b0, 32'h40, 32'h0);
      push_done(1'b1, 32'h0, 1'b1);
      mem_op(1'b0, 32'h41, 32'h0, 1);

      // Sticky error survives a normal access.
      ack_delay = 2;
      push_ram(1'b0, 32'h304, 32'h0);
      push_done(1'b1, 32'h0000_ABCD, 1'b1);
      mem_op(1'b0, 32'h304, 32'h0, 1);
      @(negedge clk);
      chk1("err_sticky", bus.bus_err, 1'b1);

      // Reset in the middle of ISSUE.
      ack_delay = 0;
      push_ram(1'b0, 32'h104, 32'h0);
      @(negedge clk);
      bus.if_addr = 32'h104;
      bus.if_req  = 1'b1;
      repeat (4) @(negedge clk);
      chk1("pre_rst_req", bus.ram_req, 1'b1);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk1("async_rst_req", bus.ram_req, 1'b0);
      chk1("async_rst_err", bus.bus_err, 1'b0);
      chk1("async_rst_done", bus.if_done, 1'b0);
      chk("async_rst_rdata", bus.if_rdata, 32'h0);
      bus.if_req = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      ack_delay = 1;
      push_ram(1'b0, 32'h104, 32'h0);
      push_done(1'b0, 32'h0050_0093, 1'b0);
      fetch_req(32'h104);
      repeat (3) @(negedge clk);

      chk("done_queue_empty", 32'(exp_q.size()), 32'd0);
      chk("ram_queue_empty", 32'(ram_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
